// File: rtl/instruction_encoder.sv
// RV32I field-bundle to instruction-word encoder with a small output FIFO.
// Define INSTR_ENCODER_RANGE_CHECK_EN to also flag immediates the format cannot represent.
module instruction_encoder #(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rs1_address,
   input  logic [4:0]  rs2_address,
   input  logic [6:0]  funct7,
   input  logic [31:0] immediate,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instruction,
   output logic        out_error,
   output logic [7:0]  error_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      FMT_U, FMT_J, FMT_I, FMT_S, FMT_B, FMT_R, FMT_BAD
   } fmt_e;

   fmt_e        fmt_c;
   logic        range_err_c;
   logic        enc_err_c;
   logic [31:0] enc_word_c;

   logic [31:0]      word_q [FIFO_DEPTH];
   logic             err_q  [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       err_cnt_q;
   logic             push, pop;

   // Format select; anything outside the supported opcode set is an error entry
   always_comb begin
      fmt_c = FMT_BAD;
      if (opcode[1:0] == 2'b11) begin
         unique case (opcode[6:2])
            5'b01101, 5'b00101:          fmt_c = FMT_U;
            5'b11011:                    fmt_c = FMT_J;
            5'b11001, 5'b00000, 5'b00100: fmt_c = FMT_I;
            5'b01000:                    fmt_c = FMT_S;
            5'b11000:                    fmt_c = FMT_B;
            5'b01100:                    fmt_c = FMT_R;
            default:                     fmt_c = FMT_BAD;
         endcase
      end
   end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   // Immediate must survive the round trip through the format's bit fields
   always_comb begin
      range_err_c = 1'b0;
      unique case (fmt_c)
         FMT_I, FMT_S: range_err_c = !((&immediate[31:11]) || !(|immediate[31:11]));
         FMT_B:        range_err_c = !((&immediate[31:12]) || !(|immediate[31:12])) || immediate[0];
         FMT_J:        range_err_c = !((&immediate[31:20]) || !(|immediate[31:20])) || immediate[0];
         FMT_U:        range_err_c = |immediate[11:0];
         default:      range_err_c = 1'b0;
      endcase
   end
`else
   assign range_err_c = 1'b0;
`endif

   assign enc_err_c = (fmt_c == FMT_BAD) || range_err_c;

   always_comb begin
      enc_word_c = 32'h0;
      unique case (fmt_c)
         FMT_U: enc_word_c = {immediate[31:12], rd, opcode};
         FMT_J: enc_word_c = {immediate[20], immediate[10:1], immediate[11],
                              immediate[19:12], rd, opcode};
         FMT_I: enc_word_c = {immediate[11:0], rs1_address, funct3, rd, opcode};
         FMT_S: enc_word_c = {immediate[11:5], rs2_address, rs1_address, funct3,
                              immediate[4:0], opcode};
         FMT_B: enc_word_c = {immediate[12], immediate[10:5], rs2_address, rs1_address,
                              funct3, immediate[4:1], immediate[11], opcode};
         FMT_R: enc_word_c = {funct7, rs2_address, rs1_address, funct3, rd, opcode};
         default: enc_word_c = 32'h0;
      endcase
      if (enc_err_c) enc_word_c = 32'h0;
   end

   assign in_ready    = (count_q != CNT_W'(FIFO_DEPTH));
   assign out_valid   = (count_q != '0);
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign instruction = out_valid ? word_q[rd_ptr_q] : 32'h0;
   assign out_error   = out_valid ? err_q[rd_ptr_q] : 1'b0;
   assign error_count = err_cnt_q;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_cnt_q <= 8'h0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            word_q[i] <= 32'h0;
            err_q[i]  <= 1'b0;
         end
      end else begin
         if (push) begin
            word_q[wr_ptr_q] <= enc_word_c;
            err_q[wr_ptr_q]  <= enc_err_c;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            if (enc_err_c && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

endmodule
